// File: rtl/tdc_pkg.sv
// Shared types and defaults for the TDC measurement sequencer.
package tdc_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ARM,
    ST_WAIT_STOP,
    ST_SETTLE,
    ST_CAPTURE,
    ST_RESULT
  } tdc_state_t;

  localparam int DEF_NUM_TAPS    = 32;
  localparam int DEF_COARSE_W    = 16;
  localparam int DEF_START_CYC   = 2;
  localparam int DEF_SETTLE_CYC  = 3;
  localparam int DEF_CLEAR_CYC   = 2;
  localparam int DEF_TIMEOUT_CYC = 1000;

  // Fine count spans 0..NUM_TAPS inclusive, hence the extra bit.
  function automatic int fine_w(input int num_taps);
    return $clog2(num_taps) + 1;
  endfunction

endpackage

// File: rtl/tdc_therm_enc.sv
// Thermometer-to-binary tap encoder. Define TDC_BUBBLE_FIX_EN to count ones
// (bubble tolerant) instead of locating the first zero.
module tdc_therm_enc
  import tdc_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int FINE_W   = fine_w(DEF_NUM_TAPS)
) (
  input  logic [NUM_TAPS-1:0] i_taps,
  output logic [FINE_W-1:0]   o_fine
);

`ifdef TDC_BUBBLE_FIX_EN
  always_comb begin
    o_fine = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      o_fine = o_fine + FINE_W'(i_taps[i]);
    end
  end
`else
  // Scanning downward leaves the lowest zero index as the final assignment.
  always_comb begin
    o_fine = FINE_W'(NUM_TAPS);
    for (int i = NUM_TAPS - 1; i >= 0; i--) begin
      if (!i_taps[i]) o_fine = FINE_W'(i);
    end
  end
`endif

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: start, coarse count, settle, capture, report, flush.
// Fine encoding selected by TDC_BUBBLE_FIX_EN inside tdc_therm_enc.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int NUM_TAPS    = DEF_NUM_TAPS,
  parameter int COARSE_W    = DEF_COARSE_W,
  parameter int START_CYC   = DEF_START_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int CLEAR_CYC   = DEF_CLEAR_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  output logic                          tdc_start,
  output logic                          tdc_clear,
  input  logic                          stop_det,
  input  logic [NUM_TAPS-1:0]           taps_raw,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [COARSE_W-1:0]           res_coarse,
  output logic [fine_w(NUM_TAPS)-1:0]   res_fine,
  output logic                          res_timeout
);

  localparam int FINE_W  = fine_w(NUM_TAPS);
  localparam int TMR_MAX = (CLEAR_CYC > SETTLE_CYC) ? CLEAR_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  tdc_state_t          r_state, w_next;
  logic [COARSE_W-1:0] r_cnt;
  logic [TMR_W-1:0]    r_tmr;
  logic [NUM_TAPS-1:0] r_taps;
  logic [FINE_W-1:0]   w_fine;
  logic                w_timeout;
  logic                w_counting, w_next_counting;

  logic                r_cmd_ready, r_start, r_clear, r_res_valid, r_res_timeout;
  logic [COARSE_W-1:0] r_res_coarse;
  logic [FINE_W-1:0]   r_res_fine;

  tdc_therm_enc #(
    .NUM_TAPS (NUM_TAPS),
    .FINE_W   (FINE_W)
  ) u_enc (
    .i_taps (r_taps),
    .o_fine (w_fine)
  );

  assign w_counting      = (r_state == ST_ARM) || (r_state == ST_WAIT_STOP);
  assign w_next_counting = (w_next == ST_ARM) || (w_next == ST_WAIT_STOP);

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_CLEAR:   if (r_tmr == TMR_W'(CLEAR_CYC - 1)) w_next = ST_IDLE;
      ST_IDLE:    if (cmd_valid) w_next = ST_ARM;
      ST_ARM, ST_WAIT_STOP: begin
        // Stop takes priority over a coincident timeout.
        if (stop_det) begin
          w_next = ST_SETTLE;
        end else if (r_cnt == COARSE_W'(TIMEOUT_CYC)) begin
          w_next    = ST_RESULT;
          w_timeout = 1'b1;
        end else if (r_state == ST_ARM && r_cnt == COARSE_W'(START_CYC - 1)) begin
          w_next = ST_WAIT_STOP;
        end
      end
      ST_SETTLE:  if (r_tmr == TMR_W'(SETTLE_CYC - 1)) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_RESULT;
      ST_RESULT:  if (res_ready) w_next = ST_CLEAR;
      default:    w_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_CLEAR;
      r_cnt         <= '0;
      r_tmr         <= '0;
      r_cmd_ready   <= 1'b0;
      r_start       <= 1'b0;
      r_clear       <= 1'b1;
      r_res_valid   <= 1'b0;
      r_res_coarse  <= '0;
      r_res_fine    <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmr   <= (w_next == r_state) ? r_tmr + 1'b1 : '0;

      // Counter freezes on exit, so it already holds the stop-time count.
      if (r_state == ST_IDLE) r_cnt <= '0;
      else if (w_counting && w_next_counting) r_cnt <= r_cnt + 1'b1;

      r_cmd_ready <= (w_next == ST_IDLE);
      r_start     <= (w_next == ST_ARM);
      r_clear     <= (w_next == ST_CLEAR);
      r_res_valid <= (w_next == ST_RESULT);

      if (w_timeout) begin
        r_res_coarse  <= COARSE_W'(TIMEOUT_CYC);
        r_res_fine    <= '0;
        r_res_timeout <= 1'b1;
      end else if (r_state == ST_CAPTURE) begin
        r_res_coarse  <= r_cnt;
        r_res_fine    <= w_fine;
        r_res_timeout <= 1'b0;
      end
    end
  end

  // Snapshot taps once the delay line has settled.
  always_ff @(posedge clk) begin
    if (r_state == ST_SETTLE && w_next == ST_CAPTURE) r_taps <= taps_raw;
  end

  assign cmd_ready   = r_cmd_ready;
  assign tdc_start   = r_start;
  assign tdc_clear   = r_clear;
  assign res_valid   = r_res_valid;
  assign res_coarse  = r_res_coarse;
  assign res_fine    = r_res_fine;
  assign res_timeout = r_res_timeout;

endmodule
